enc_ctrl: RTL and testbench

Sequencing controller for the ECC encoder pipeline. Accepts one encode request at a time from the register/APB side and validates `work_mod`. Latches and masks the info word, then walks one-hot stage enables through the PIPE_DEPTH encoder stages. Captures the final codeword and returns it with a one-cycle `done` pulse. Sits between the register file and the encoder stage chain (the last stage inserts the overall parity bit).

---
 rtl/enc_ctrl.sv | 146 ++++++++++++++
 tb/tb_enc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_ctrl.sv
// Sequencing controller for the ECC encoder pipeline: validates the mode, masks the info word,
// walks one-hot stage enables and captures the codeword. Optional statistics under ENC_CTRL_STATS_EN.
module enc_ctrl #(
    parameter int AMBA_WORD          = 32,
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int PIPE_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [AMBA_WORD-1:0]          work_mod_in,
    input  logic [AMBA_WORD-1:0]          data_in,
    output logic                          ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] stage_data,
    output logic [AMBA_WORD-1:0]          stage_mod,
    output logic [PIPE_DEPTH-1:0]         stage_en,
    input  logic [MAX_CODEWORD_WIDTH-1:0] pipe_data_in,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          done,
    output logic                          mod_err,
    output logic [15:0]                   op_count,
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_DEPTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 mode_legal;
    logic [AMBA_WORD-1:0] masked_word;

    assign state_dbg = state;

    // Modes wider than the configured codeword are rejected like out-of-range modes.
    always_comb begin
        mode_legal  = 1'b0;
        masked_word = '0;
        if (work_mod_in == AMBA_WORD'(0)) begin
            mode_legal  = 1'b1;
            masked_word = data_in & AMBA_WORD'(32'h0000_000F);
        end else if (work_mod_in == AMBA_WORD'(1)) begin
            mode_legal  = (MAX_CODEWORD_WIDTH >= 16);
            masked_word = data_in & AMBA_WORD'(32'h0000_07FF);
        end else if (work_mod_in == AMBA_WORD'(2)) begin
            mode_legal  = (MAX_CODEWORD_WIDTH == 32);
            masked_word = data_in & AMBA_WORD'(32'h03FF_FFFF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ready      <= 1'b1;
            stage_data <= '0;
            stage_mod  <= '0;
            stage_en   <= '0;
            data_out   <= '0;
            done       <= 1'b0;
            mod_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            mod_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (mode_legal) begin
                            stage_mod  <= work_mod_in;
                            stage_data <= MAX_CODEWORD_WIDTH'(masked_word);
                            ready      <= 1'b0;
                            state      <= S_LOAD;
                        end else begin
                            mod_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                    if (abort) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        stage_en <= PIPE_DEPTH'(1);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        stage_en <= '0;
                        ready    <= 1'b1;
                        state    <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        stage_en <= '0;
                        state    <= S_CAPT;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        stage_en <= stage_en << 1;
                    end
                end
                S_CAPT: begin
                    // An abort here must leave the previous codeword in data_out.
                    if (abort) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        data_out <= pipe_data_in;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    stage_en <= '0;
                    ready    <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ENC_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (state == S_DONE && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_enc_ctrl.sv
// Bench for enc_ctrl: table vectors, randomized operations against a cycle-level reference model,
// and hand sequences for abort, back-to-back, narrow-codeword rejection, statistics and async reset.
module tb_enc_ctrl;

    localparam int PD = 2;

    logic        clk, rst, start, abort;
    logic [31:0] work_mod_in, data_in, pipe_data_in;
    logic        ready, done, mod_err;
    logic [31:0] stage_data, stage_mod, data_out;
    logic [PD-1:0] stage_en;
    logic [15:0] op_count;
    logic [2:0]  state_dbg;

    logic        start16;
    logic [31:0] mod16, data16;
    logic [15:0] pipe16, stage_data16, data_out16;
    logic        ready16, done16, mod_err16;
    logic [31:0] stage_mod16;
    logic [PD-1:0] stage_en16;
    logic [15:0] op_count16;
    logic [2:0]  state_dbg16;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_done = 0;
    int done_cyc = 0;
    logic [31:0] exp_sd = 0, exp_sm = 0, exp_do = 0;
    logic [31:0] exp_q[$];

    enc_ctrl #(.AMBA_WORD(32), .MAX_CODEWORD_WIDTH(32), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .work_mod_in(work_mod_in), .data_in(data_in), .ready(ready),
        .stage_data(stage_data), .stage_mod(stage_mod), .stage_en(stage_en),
        .pipe_data_in(pipe_data_in), .data_out(data_out), .done(done),
        .mod_err(mod_err), .op_count(op_count), .state_dbg(state_dbg)
    );

    enc_ctrl #(.AMBA_WORD(32), .MAX_CODEWORD_WIDTH(16), .PIPE_DEPTH(PD)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .abort(1'b0),
        .work_mod_in(mod16), .data_in(data16), .ready(ready16),
        .stage_data(stage_data16), .stage_mod(stage_mod16), .stage_en(stage_en16),
        .pipe_data_in(pipe16), .data_out(data_out16), .done(done16),
        .mod_err(mod_err16), .op_count(op_count16), .state_dbg(state_dbg16)
    );

    // clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model
    function automatic logic legal_f(input logic [31:0] m, input int mcw);
        return (m < 3) && (m != 1 || mcw >= 16) && (m != 2 || mcw == 32);
    endfunction

    function automatic logic [31:0] mask_f(input logic [31:0] m, input logic [31:0] d);
        longint keep_bits;
        keep_bits = (m == 0) ? 4 : (m == 1) ? 11 : 26;
        return 32'(longint'(d) % (longint'(1) << keep_bits));
    endfunction

    function automatic logic [31:0] exp_oc();
`ifdef ENC_CTRL_STATS_EN
        return (n_done > 65535) ? 32'd65535 : 32'(n_done);
`else
        return 32'd0;
`endif
    endfunction

    task automatic reset_dut();
        rst = 0;
        start = 0; abort = 0; start16 = 0;
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_stage_en", {30'd0, stage_en}, 0);
        chk("rst_stage_data", stage_data, 0);
        chk("rst_stage_mod", stage_mod, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_mod_err", {31'd0, mod_err}, 0);
        chk("rst_op_count", {16'd0, op_count}, 0);
        rst = 1;
        exp_sd = 0; exp_sm = 0; exp_do = 0; n_done = 0;
        exp_q.delete();
        step();
    endtask

    // Driver: called in a cycle where ready=1; returns in the next cycle where ready=1.
    task automatic do_op(input logic [31:0] mode, input logic [31:0] data, input logic [31:0] pipe,
                         input int abort_at, input int start_at, input logic exp_legal,
                         input logic [31:0] sd_in);
        bit aborted;
        logic [31:0] exp_en;
        aborted = (abort_at >= 1 && abort_at <= PD + 2);
        work_mod_in = mode; data_in = data; start = 1; abort = 0;
        step();
        start = 0;
        if (!exp_legal) begin
            chk("rej_mod_err", {31'd0, mod_err}, 1);
            chk("rej_ready", {31'd0, ready}, 1);
            chk("rej_stage_en", {30'd0, stage_en}, 0);
            chk("rej_stage_data", stage_data, sd_in);
            chk("rej_stage_mod", stage_mod, exp_sm);
            step();
            chk("rej_mod_err_clr", {31'd0, mod_err}, 0);
            chk("rej_stage_en2", {30'd0, stage_en}, 0);
            return;
        end
        exp_sd = sd_in; exp_sm = mode;
        if (!aborted) exp_q.push_back(pipe);
        for (int c = 1; c <= PD + 4; c++) begin
            if (aborted && c == abort_at + 1) begin
                abort = 0; start = 0;
                chk("abort_ready", {31'd0, ready}, 1);
                chk("abort_stage_en", {30'd0, stage_en}, 0);
                chk("abort_no_done", {31'd0, done}, 0);
                chk("abort_data_out", data_out, exp_do);
                return;
            end
            exp_en = (c >= 2 && c <= PD + 1) ? (32'd1 << (c - 2)) : 32'd0;
            chk("ready", {31'd0, ready}, (c == PD + 4) ? 1 : 0);
            chk("stage_en", {30'd0, stage_en}, exp_en);
            chk("done", {31'd0, done}, (c == PD + 3) ? 1 : 0);
            chk("mod_err_idle", {31'd0, mod_err}, 0);
            chk("stage_data", stage_data, exp_sd);
            chk("stage_mod", stage_mod, exp_sm);
            if (c == 1) chk("op_count_pre", {16'd0, op_count}, exp_oc());
            if (c == PD + 3) begin
                done_cyc = cyc;
                n_done++;
                exp_do = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                chk("data_out_done", data_out, exp_do);
            end else begin
                chk("data_out_hold", data_out, exp_do);
            end
            if (c == PD + 4) begin
                chk("op_count_post", {16'd0, op_count}, exp_oc());
                abort = 0; start = 0;
                return;
            end
            abort = (c == abort_at);
            start = (c == start_at);
            if (c == start_at) begin
                work_mod_in = 32'($urandom_range(0, 2));
                data_in = $urandom;
            end
            pipe_data_in = (c == PD + 2) ? pipe : $urandom;
            step();
        end
    endtask

    typedef struct {
        logic [31:0] mode;
        logic [31:0] data;
        logic [31:0] pipe;
        int          abort_at;
        int          start_at;
        logic        legal;
        logic [31:0] sd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d1;
        vecs[0] = '{32'd0, 32'hFFFF_FFF5, 32'h0000_00A5, 0, 0, 1'b1, 32'h0000_0005};
        vecs[1] = '{32'd2, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 1'b1, 32'h03FF_FFFF};
        vecs[2] = '{32'd1, 32'hFFFF_FFFF, 32'h0000_0ABC, 0, 0, 1'b1, 32'h0000_07FF};
        vecs[3] = '{32'd3, 32'h0000_1234, 32'h0,         0, 0, 1'b0, 32'h0000_07FF};
        vecs[4] = '{32'd2, 32'hA5A5_A5A5, 32'hFFFF_0000, 3, 0, 1'b1, 32'h01A5_A5A5};
        vecs[5] = '{32'd0, 32'h0000_00FA, 32'h0BAD_F00D, 0, 2, 1'b1, 32'h0000_000A};
        vecs[6] = '{32'd1, 32'hFFFF_0001, 32'hDEAD_BEEF, 5, 0, 1'b1, 32'h0000_0001};

        work_mod_in = 0; data_in = 0; pipe_data_in = 0;
        mod16 = 0; data16 = 0; pipe16 = 0;
        reset_dut();

        foreach (vecs[i])
            do_op(vecs[i].mode, vecs[i].data, vecs[i].pipe, vecs[i].abort_at,
                  vecs[i].start_at, vecs[i].legal, vecs[i].sd);

        do_op(32'h8000_0002, 32'h1, 32'h0, 0, 0, 1'b0, exp_sd);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] m, d, p;
            int ab, st;
            m  = (i % 7 == 6) ? $urandom : 32'($urandom_range(0, 4));
            d  = $urandom;
            p  = $urandom;
            ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, PD + 3)) : 0;
            st = ($urandom_range(0, 9) < 3) ? int'($urandom_range(2, PD + 2)) : 0;
            if (legal_f(m, 32)) do_op(m, d, p, ab, st, 1'b1, mask_f(m, d));
            else                do_op(m, d, p, ab, st, 1'b0, exp_sd);
        end

        // back-to-back completions
        do_op(32'd0, 32'h0000_0003, 32'h0000_0011, 0, 0, 1'b1, 32'h3);
        d1 = done_cyc;
        do_op(32'd1, 32'h0000_0456, 32'h0000_0022, 0, 0, 1'b1, 32'h456);
        chk("b2b_spacing", 32'(done_cyc - d1), PD + 4);

        // narrow codeword instance: mode 2 rejected, mode 1 accepted
        mod16 = 2; data16 = 32'hFFFF_FFFF; start16 = 1;
        step();
        start16 = 0;
        chk("w16_mod_err", {31'd0, mod_err16}, 1);
        chk("w16_ready", {31'd0, ready16}, 1);
        chk("w16_stage_en", {30'd0, stage_en16}, 0);
        step();
        chk("w16_mod_err_clr", {31'd0, mod_err16}, 0);
        mod16 = 1; start16 = 1;
        step();
        start16 = 0;
        chk("w16_mode1_data", {16'd0, stage_data16}, 32'h0000_07FF);
        chk("w16_mode1_busy", {31'd0, ready16}, 0);
        for (int k = 0; k < PD + 4; k++) step();

        // statistics: 3 completed + 1 aborted + 1 rejected
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] d;
            d = $urandom;
            do_op(32'd0, d, $urandom, 0, 0, 1'b1, mask_f(32'd0, d));
        end
        do_op(32'd2, 32'h1, 32'h2, 2, 0, 1'b1, 32'h1);
        do_op(32'd7, 32'h1, 32'h2, 0, 0, 1'b0, exp_sd);
`ifdef ENC_CTRL_STATS_EN
        chk("stats_op_count", {16'd0, op_count}, 3);
`else
        chk("stats_op_count", {16'd0, op_count}, 0);
`endif

        // asynchronous reset in the middle of RUN
        work_mod_in = 0; data_in = 32'h9; start = 1;
        step();
        start = 0;
        step();
        chk("mid_run_en", {30'd0, stage_en}, 1);
        #2 rst = 0;
        #1;
        chk("arst_ready", {31'd0, ready}, 1);
        chk("arst_stage_en", {30'd0, stage_en}, 0);
        chk("arst_op_count", {16'd0, op_count}, 0);
        chk("arst_stage_data", stage_data, 0);
        chk("arst_data_out", data_out, 0);
        step();
        step();
        chk("arst_no_done", {31'd0, done}, 0);
        rst = 1;
        exp_sd = 0; exp_sm = 0; exp_do = 0; n_done = 0;
        step();
        chk("post_rst_ready", {31'd0, ready}, 1);
        do_op(32'd1, 32'h0000_0ABC, 32'h0000_5A5A, 0, 0, 1'b1, 32'h0000_02BC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
